// File: rtl/enc_sys_arbiter.sv
// ---------------------------------------------------------------------------
// enc_sys_arbiter
// Shares one encrypt/decrypt system between two byte-stream requesters.
// Whole bursts are granted round-robin. Each burst goes through the states
// IDLE -> (CONFIG) -> STREAM -> DRAIN -> IDLE. The CONFIG state runs only
// when the owning channel changes. It writes that channel's 32-bit config
// word into the system. The system's decrypted bytes are routed back to the
// owner.
//
// Optional feature: define ARB_STATS_EN to enable the per-channel grant
// counters (grant_cnt0/grant_cnt1). When it is undefined, those ports are
// tied to zero and no counter flops are built.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   req_valid[1:0], req_last[1:0], req_data0/1[7:0]
//                 per-channel byte stream in; req_ready[1:0] accepts
//   cfg_word0/1   per-channel system config words (held stable)
//   rsp_valid[1:0], rsp_data[7:0]
//                 decrypted byte back to the owning channel
//   sys_enable, sys_data, sys_cfg_wen, sys_cfg_data
//                 drive the wrapper's enable/data_in_encrypt/cfg_* inputs
//   sys_valid, sys_rdata
//                 wrapper decrypt_valid_out / decrypted_data
//   err           sticky error (drain timeout or spurious return)
//   grant_cnt0/1  bursts granted per channel (saturating)
// ---------------------------------------------------------------------------
module enc_sys_arbiter #(
   parameter int MAX_BURST       = 16,
   parameter int MAX_OUTSTANDING = 8,
   parameter int DRAIN_TIMEOUT   = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_last,
   input  logic [7:0]  req_data0,
   input  logic [7:0]  req_data1,
   output logic [1:0]  req_ready,
   input  logic [31:0] cfg_word0,
   input  logic [31:0] cfg_word1,
   output logic [1:0]  rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        sys_enable,
   output logic [7:0]  sys_data,
   output logic        sys_cfg_wen,
   output logic [31:0] sys_cfg_data,
   input  logic        sys_valid,
   input  logic [7:0]  sys_rdata,
   output logic        err,
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONFIG = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t          state;
   logic            rr;            // channel that has priority on a tie
   logic            owner;         // channel holding the system
   logic            loaded_valid;  // system currently holds a channel's config
   logic            loaded_ch;
   logic [OW-1:0]   outstanding;
   logic [7:0]      beat;
   logic [TW-1:0]   drain_cnt;

   logic            winner;
   logic            can_issue;
   logic            accept;
   logic [7:0]      sel_data;
   logic            sel_last;
   logic [7:0]      beat_nxt;
   logic            burst_end;
   logic            ret_ok;
   logic            spurious;

   // Arbitration, handshake and return-path decode from the registered state
   always_comb begin
      winner = 1'b0;
      if (req_valid[0] && req_valid[1]) begin
         winner = rr;
      end else if (req_valid[1]) begin
         winner = 1'b1;
      end else begin
         winner = 1'b0;
      end

      can_issue = (state == STREAM) && (outstanding < OW'(MAX_OUTSTANDING));
      sel_data  = owner ? req_data1 : req_data0;
      sel_last  = owner ? req_last[1] : req_last[0];
      accept    = can_issue && (owner ? req_valid[1] : req_valid[0]);
      beat_nxt  = beat + 8'd1;
      burst_end = sel_last || (beat_nxt == 8'(MAX_BURST));

      if (can_issue) begin
         req_ready = owner ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end

      // A return is only legitimate while something is in flight. The owner
      // is held through DRAIN, so a return always belongs to the owner.
      ret_ok   = sys_valid && (outstanding != {OW{1'b0}});
      spurious = sys_valid && (outstanding == {OW{1'b0}});
      if (ret_ok) begin
         rsp_valid = owner ? 2'b10 : 2'b01;
         rsp_data  = sys_rdata;
      end else begin
         rsp_valid = 2'b00;
         rsp_data  = 8'h00;
      end
   end

   // Burst FSM, in-flight accounting and registered system-side outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         rr           <= 1'b0;
         owner        <= 1'b0;
         loaded_valid <= 1'b0;
         loaded_ch    <= 1'b0;
         outstanding  <= {OW{1'b0}};
         beat         <= 8'd0;
         drain_cnt    <= {TW{1'b0}};
         err          <= 1'b0;
         sys_enable   <= 1'b0;
         sys_data     <= 8'h00;
         sys_cfg_wen  <= 1'b0;
         sys_cfg_data <= 32'h0000_0000;
      end else begin
         sys_cfg_wen <= 1'b0;
         sys_enable  <= accept;
         if (accept) begin
            sys_data <= sel_data;
         end

         // An issue and a return in the same cycle cancel out
         case ({accept, ret_ok})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase

         if (spurious) begin
            err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (|req_valid) begin
                  owner <= winner;
                  if (loaded_valid && (loaded_ch == winner)) begin
                     state <= STREAM;
                  end else begin
                     state        <= CONFIG;
                     sys_cfg_wen  <= 1'b1;
                     sys_cfg_data <= winner ? cfg_word1 : cfg_word0;
                  end
               end
            end
            CONFIG: begin
               loaded_valid <= 1'b1;
               loaded_ch    <= owner;
               state        <= STREAM;
            end
            STREAM: begin
               if (accept) begin
                  if (burst_end) begin
                     beat      <= 8'd0;
                     drain_cnt <= {TW{1'b0}};
                     state     <= DRAIN;
                  end else begin
                     beat <= beat_nxt;
                  end
               end
            end
            DRAIN: begin
               if (outstanding == {OW{1'b0}}) begin
                  rr    <= ~owner;
                  state <= IDLE;
               end else if (drain_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
                  // The system stopped answering; drop the lost bytes and recover
                  err         <= 1'b1;
                  outstanding <= {OW{1'b0}};
                  state       <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARB_STATS_EN
   logic grant_evt;

   // A grant happens on any IDLE cycle that has a requester
   always_comb begin
      grant_evt = (state == IDLE) && (|req_valid);
   end

   // Saturating per-channel grant counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_cnt0 <= 16'h0000;
         grant_cnt1 <= 16'h0000;
      end else begin
         if (grant_evt && !winner && (grant_cnt0 != 16'hFFFF)) begin
            grant_cnt0 <= grant_cnt0 + 16'h0001;
         end
         if (grant_evt && winner && (grant_cnt1 != 16'hFFFF)) begin
            grant_cnt1 <= grant_cnt1 + 16'h0001;
         end
      end
   end
`else
   assign grant_cnt0 = 16'h0000;
   assign grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_enc_sys_arbiter.sv
// Scoreboard bench for enc_sys_arbiter. Expected config words, issued bytes
// and per-channel returned bytes are queued by the stimulus. A monitor pops
// and compares them whenever the DUT presents the corresponding output.
module tb_enc_sys_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        v0, v1, l0, l1;
   logic [7:0]  d0, d1;
   logic [1:0]  req_valid, req_last, req_ready, rsp_valid;
   logic [7:0]  rsp_data, sys_data;
   logic [31:0] cfg_word0, cfg_word1, sys_cfg_data;
   logic        sys_enable, sys_cfg_wen, err;
   logic        sys_valid = 1'b0;
   logic [7:0]  sys_rdata = 8'h00;
   logic [15:0] grant_cnt0, grant_cnt1;

   assign req_valid = {v1, v0};
   assign req_last  = {l1, l0};

   enc_sys_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last),
      .req_data0(d0), .req_data1(d1), .req_ready(req_ready),
      .cfg_word0(cfg_word0), .cfg_word1(cfg_word1),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .sys_enable(sys_enable), .sys_data(sys_data),
      .sys_cfg_wen(sys_cfg_wen), .sys_cfg_data(sys_cfg_data),
      .sys_valid(sys_valid), .sys_rdata(sys_rdata),
      .err(err), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          inflight = 0;
   int          iss_seen = 0;
   bit          stall = 1'b0;
   logic [31:0] cfg_q [$];
   logic [7:0]  iss_q [$];
   logic [7:0]  rsp0_q [$];
   logic [7:0]  rsp1_q [$];
   logic [7:0]  model_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_line(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%h required=nothing", name, act);
   endtask

   // Wrapper model: returns each issued byte one cycle later, one per cycle,
   // and holds them while stalled.
   always @(posedge clk) begin
      if (sys_enable) model_q.push_back(sys_data);
      if (!stall && model_q.size() > 0) begin
         sys_valid <= 1'b1;
         sys_rdata <= model_q.pop_front();
      end else begin
         sys_valid <= 1'b0;
         sys_rdata <= 8'h00;
      end
   end

   // Monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) inflight = 0;
         if (sys_cfg_wen) begin
            chk("cfg_after_drain", 32'(inflight), 32'd0);
            if (cfg_q.size() == 0) fail_line("cfg_unexpected", sys_cfg_data);
            else chk("cfg_word", sys_cfg_data, cfg_q.pop_front());
         end
         if (sys_enable) begin
            inflight++;
            iss_seen++;
            if (iss_q.size() == 0) fail_line("iss_unexpected", 32'(sys_data));
            else chk("iss_data", 32'(sys_data), 32'(iss_q.pop_front()));
         end
         if (rsp_valid == 2'b11) fail_line("rsp_both", 32'(rsp_valid));
         if (rsp_valid[0]) begin
            inflight--;
            if (rsp0_q.size() == 0) fail_line("rsp0_unexpected", 32'(rsp_data));
            else chk("rsp0_data", 32'(rsp_data), 32'(rsp0_q.pop_front()));
         end
         if (rsp_valid[1]) begin
            inflight--;
            if (rsp1_q.size() == 0) fail_line("rsp1_unexpected", 32'(rsp_data));
            else chk("rsp1_data", 32'(rsp_data), 32'(rsp1_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
      if (ch == 0) begin v0 = v; d0 = d; l0 = l; end
      else begin v1 = v; d1 = d; l1 = l; end
   endtask

   task automatic drive_burst(input int ch, input int n, input logic [7:0] base,
                              input logic [7:0] step, input bit last_at_end);
      for (int i = 0; i < n; i++) begin
         int  waitc = 0;
         bit  acc = 1'b0;
         logic [7:0] b;
         b = base + 8'(i) * step;
         @(negedge clk);
         set_ch(ch, 1'b1, b, last_at_end && (i == n - 1));
         while (!acc) begin
            acc = req_ready[ch];
            @(posedge clk);
            if (!acc) begin
               waitc++;
               if (waitc > 300) begin
                  fail_line("accept_timeout", 32'(b));
                  set_ch(ch, 1'b0, 8'h00, 1'b0);
                  return;
               end
               @(negedge clk);
            end
         end
      end
      @(negedge clk);
      set_ch(ch, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic chk_reset_outputs();
      chk("reset_misc", 32'({req_ready, rsp_valid, rsp_data, sys_enable, sys_data,
                             sys_cfg_wen, err}), 32'd0);
      chk("reset_cfg_data", sys_cfg_data, 32'd0);
      chk("reset_grant", {grant_cnt1, grant_cnt0}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk_reset_outputs();
      end
      rst = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((iss_q.size() + rsp0_q.size() + rsp1_q.size() + cfg_q.size()) != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("cfg_q_empty", 32'(cfg_q.size()), 32'd0);
      chk("iss_q_empty", 32'(iss_q.size()), 32'd0);
      chk("rsp0_q_empty", 32'(rsp0_q.size()), 32'd0);
      chk("rsp1_q_empty", 32'(rsp1_q.size()), 32'd0);
   endtask

   initial begin
      int iss_base;
      rst = 1'b0;
      v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
      cfg_word0 = 32'hFAAFBAB3;
      cfg_word1 = 32'h12345601;
      do_reset();

      // T1: single ch0 burst A1,B2,C3
      cfg_q.push_back(32'hFAAFBAB3);
      iss_q = '{8'hA1, 8'hB2, 8'hC3};
      rsp0_q = '{8'hA1, 8'hB2, 8'hC3};
      drive_burst(0, 3, 8'hA1, 8'h11, 1'b1);
      wait_idle();

      // T2: second ch0 burst reuses the loaded config (no cfg pulse queued)
      iss_q = '{8'hD4, 8'hE5};
      rsp0_q = '{8'hD4, 8'hE5};
      drive_burst(0, 2, 8'hD4, 8'h11, 1'b1);
      wait_idle();
      chk("err_after_t2", 32'(err), 32'd0);

      // T3: both channels from reset: ch0, ch1, ch0
      do_reset();
      cfg_q = '{32'hFAAFBAB3, 32'h12345601, 32'hFAAFBAB3};
      iss_q = '{8'h11, 8'h12, 8'h21, 8'h22, 8'h13, 8'h14};
      rsp0_q = '{8'h11, 8'h12, 8'h13, 8'h14};
      rsp1_q = '{8'h21, 8'h22};
      fork
         begin
            drive_burst(0, 2, 8'h11, 8'h01, 1'b1);
            drive_burst(0, 2, 8'h13, 8'h01, 1'b1);
         end
         drive_burst(1, 2, 8'h21, 8'h01, 1'b1);
      join
      wait_idle();

      // T4: ch1 streams 40 bytes without last; ch0 slips in after the first 16
      cfg_q = '{32'h12345601, 32'hFAAFBAB3, 32'h12345601};
      for (int i = 0; i < 16; i++) iss_q.push_back(8'h40 + 8'(i));
      iss_q.push_back(8'h90);
      iss_q.push_back(8'h91);
      for (int i = 16; i < 40; i++) iss_q.push_back(8'h40 + 8'(i));
      for (int i = 0; i < 40; i++) rsp1_q.push_back(8'h40 + 8'(i));
      rsp0_q = '{8'h90, 8'h91};
      fork
         drive_burst(1, 40, 8'h40, 8'h01, 1'b0);
         begin
            repeat (5) @(negedge clk);
            drive_burst(0, 2, 8'h90, 8'h01, 1'b1);
         end
      join
      wait_idle();
      chk("err_after_t4", 32'(err), 32'd0);

      // T5a: stalled returns cap issue at 8 outstanding
      do_reset();
      stall = 1'b1;
      cfg_q.push_back(32'hFAAFBAB3);
      for (int i = 0; i < 10; i++) begin
         iss_q.push_back(8'h30 + 8'(i));
         rsp0_q.push_back(8'h30 + 8'(i));
      end
      iss_base = iss_seen;
      fork
         drive_burst(0, 10, 8'h30, 8'h01, 1'b1);
         begin
            repeat (20) @(negedge clk);
            chk("ready_at_cap", 32'(req_ready), 32'd0);
            chk("issued_at_cap", 32'(iss_seen - iss_base), 32'd8);
            chk("no_rsp_while_stalled", 32'(rsp0_q.size()), 32'd10);
            stall = 1'b0;
         end
      join
      wait_idle();
      chk("err_after_t5a", 32'(err), 32'd0);

      // T5b: returns never come; DRAIN times out after 32 cycles
      stall = 1'b1;
      iss_q = '{8'h3A, 8'h3B};
      drive_burst(0, 2, 8'h3A, 8'h01, 1'b1);
      repeat (31) @(posedge clk);
      @(negedge clk);
      chk("err_before_timeout", 32'(err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("err_timeout", 32'(err), 32'd1);
      chk("ready_after_timeout", 32'(req_ready), 32'd0);
      model_q.delete();
      stall = 1'b0;
      wait_idle();

      // T6: reset during byte 2, spurious return afterwards, then re-grant
      do_reset();
      stall = 1'b1;
      cfg_q.push_back(32'hFAAFBAB3);
      iss_q = '{8'h70, 8'h71};
      drive_burst(0, 2, 8'h70, 8'h01, 1'b0);
      set_ch(0, 1'b1, 8'h72, 1'b0);
      #2;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_reset_outputs();
      end
      set_ch(0, 1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      stall = 1'b0;
      repeat (4) @(negedge clk);
      chk("err_spurious", 32'(err), 32'd1);
      cfg_q.push_back(32'hFAAFBAB3);
      iss_q = '{8'h72, 8'h73};
      rsp0_q = '{8'h72, 8'h73};
      drive_burst(0, 2, 8'h72, 8'h01, 1'b1);
      wait_idle();
`ifdef ARB_STATS_EN
      chk("grant_cnt0", 32'(grant_cnt0), 32'd1);
`else
      chk("grant_cnt0", 32'(grant_cnt0), 32'd0);
`endif
      chk("grant_cnt1", 32'(grant_cnt1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/enc_sys_arbiter.md
Name: enc_sys_arbiter

Overview:
- Shares one encrypt_decrypt_system_wrapper instance between two byte-stream requesters (ch0, ch1).
- Grants whole bursts round-robin and reprograms the system's 32-bit config word (cfg_wen/cfg_data_in) whenever ownership changes.
- Drains in-flight bytes before handing over, then routes decrypted results back to the owning channel.
- Sits between requester logic and the wrapper's enable/data_in_encrypt/cfg_* inputs and decrypt_valid_out/decrypted_data outputs.

Parameters:
- MAX_BURST, 16: max bytes per grant before forced rotation (1..255).
- MAX_OUTSTANDING, 8: max bytes issued but not yet returned via decrypt_valid_out.
- DRAIN_TIMEOUT, 32: cycles allowed in DRAIN before error recovery.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  2  per-channel byte valid, bit n = ch n.
- req_last  in  2  per-channel last byte of burst.
- req_data0  in  8  ch0 plaintext byte.
- req_data1  in  8  ch1 plaintext byte.
- req_ready  out  2  per-channel accept.
- cfg_word0  in  32  ch0 system config, held stable.
- cfg_word1  in  32  ch1 system config, held stable.
- rsp_valid  out  2  decrypted byte valid for ch n.
- rsp_data  out  8  decrypted byte, shared by both channels.
- sys_enable  out  1  to wrapper enable.
- sys_data  out  8  to wrapper data_in_encrypt.
- sys_cfg_wen  out  1  to wrapper cfg_wen.
- sys_cfg_data  out  32  to wrapper cfg_data_in.
- sys_valid  in  1  from wrapper decrypt_valid_out.
- sys_rdata  in  8  from wrapper decrypted_data.
- err  out  1  sticky error flag.
- grant_cnt0  out  16  ch0 bursts granted (optional feature).
- grant_cnt1  out  16  ch1 bursts granted (optional feature).

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, rr pointer = ch0 priority, loaded_ch invalid, outstanding=0, beat=0, err=0.
- IDLE: if any req_valid, pick winner. The channel not granted last has priority; with a single requester, that requester wins.
  - Winner == loaded_ch and loaded valid -> STREAM.
  - Otherwise -> CONFIG.
  - No valid requests -> stay in IDLE.
- CONFIG: exactly one cycle with sys_cfg_wen=1 and sys_cfg_data=cfg_wordN (registered). Record loaded_ch=N, then go to STREAM.
- STREAM:
  - req_ready[owner]=1 when outstanding<MAX_OUTSTANDING; the other ready bit = 0.
  - On valid&ready: next cycle sys_enable=1 and sys_data=req_dataN (registered, 1-cycle latency); outstanding++ and beat++.
  - Otherwise sys_enable=0 next cycle.
  - Accepted beat with req_last=1, or beat reaching MAX_BURST -> DRAIN; beat clears.
- DRAIN: ready=0. When outstanding==0, go to IDLE and flip the rr pointer away from the owner.
  - DRAIN_TIMEOUT cycles without reaching 0 -> err=1, outstanding cleared, go to IDLE.
- Return path: sys_valid=1 -> rsp_valid[owner]=1 and rsp_data=sys_rdata in the same cycle (combinational); outstanding--.
  - Owner is held through DRAIN, so every return maps to the issuing channel.
- Simultaneous issue and return in one cycle: outstanding unchanged.
- sys_valid with outstanding==0: err=1, no rsp_valid, counter stays 0.
- outstanding never exceeds MAX_OUTSTANDING. Width = clog2(MAX_OUTSTANDING+1).
- Reset mid-burst: returns to IDLE and invalidates loaded_ch, so the next grant always reconfigures. In-flight returns after reset are treated as spurious (err).

Optional Feature:
- Macro ARB_STATS_EN defined: grant_cnt0/grant_cnt1 increment on each IDLE->CONFIG or IDLE->STREAM grant to that channel. They saturate at 16'hFFFF and reset to 0.
- Macro undefined: ports remain, driven constant 0, no counter flops.

Test Plan:
- ch0 only, cfg_word0=32'hFAAFBAB3, 3-byte burst A1,B2,C3 -> one sys_cfg_wen pulse with FAAFBAB3, sys_data A1,B2,C3 on consecutive cycles, rsp_valid[0] with A1,B2,C3 returned, rsp_valid[1] never set.
- ch0 burst then second ch0 burst -> no second sys_cfg_wen; STREAM entered directly from IDLE.
- Both valid from reset, 2-byte bursts each, cfg_word1=32'h12345601 -> ch0 granted first; ch1 config pulse issued only after ch0 outstanding reaches 0; ch1 granted next, then ch0 again.
- ch1 holds req_valid for 40 bytes, no req_last, MAX_BURST=16 -> forced DRAIN after 16, 16, 8 bytes; an interleaved ch0 request is granted between bursts.
- Wrapper model stalls returns (sys_valid held 0) -> req_ready drops after 8 issued bytes; in DRAIN, err=1 after 32 cycles and state returns to IDLE.
- Assert rst=0 during burst byte 2, release, re-request -> all outputs 0 during reset; fresh sys_cfg_wen on re-grant; with ARB_STATS_EN, grant_cnt0 counts 1 after reset.
